reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8; number of architectural registers, legal range 2..64.
REQ-002 SHALL have parameter IDX_W, default 3; register index width, at least ceil(log2(NUM_REGS)).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 means reg 0 maps to bit NUM_REGS-1, and 0 means reg 0 maps to bit 0.
REQ-004 SHALL have parameter ZERO_REG, default 0; 1 means reg 0 is hardwired and never tracked.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 issue_valid  input  1  instruction requests issue this cycle.
REQ-008 issue_rd  input  IDX_W  destination register index.
REQ-009 issue_rs1, issue_rs2  input  IDX_W each  source register indices.
REQ-010 retire_valid  input  1  a write-back completes this cycle.
REQ-011 retire_rd  input  IDX_W  register written back.
REQ-012 stall  output  1  combinational; issue blocked this cycle.
REQ-013 rd_onehot  output  NUM_REGS  registered one-hot decode of the last accepted issue_rd.
REQ-014 rd_valid  output  1  registered; one-cycle pulse qualifying rd_onehot.
REQ-015 busy  output  NUM_REGS  registered pending-write bitmap, using the same bit ordering as rd_onehot.
REQ-016 busy_count  output  IDX_W+1  registered population count of busy.
REQ-017 err  output  1  registered sticky error flag.

Function
REQ-018 Decode SHALL map index i to bit (NUM_REGS-1-i) when MSB_FIRST=1 and to bit i when MSB_FIRST=0; an index >= NUM_REGS SHALL decode to all zeros.
REQ-019 stall SHALL equal issue_valid AND (busy bit of rs1, rs2 or rd set), evaluated on current busy with no same-cycle retire bypass.
REQ-020 With ZERO_REG=1, index 0 SHALL never contribute to stall and SHALL never set busy.
REQ-021 Accept SHALL be issue_valid AND NOT stall; on accept, the busy bit of issue_rd SHALL be set at the next edge.
REQ-022 On accept, rd_onehot SHALL load decode(issue_rd) and rd_valid SHALL be 1 for exactly one cycle (latency 1); otherwise rd_valid SHALL be 0 and rd_onehot SHALL hold its value.
REQ-023 retire_valid SHALL clear the busy bit of retire_rd at the next edge.
REQ-024 When accept and retire target the same register in one cycle, set SHALL win and the bit SHALL end at 1.
REQ-025 When accept and retire target different registers in one cycle, both updates SHALL apply.
REQ-026 busy_count SHALL equal the popcount of the next busy value, registered with busy, so the two are never skewed.
REQ-027 err SHALL set on any of: retire of a non-busy register (ignoring reg 0 when ZERO_REG=1); any valid index >= NUM_REGS; accept with issue_rd >= NUM_REGS (which sets no busy bit).
REQ-028 err SHALL remain set until reset; erroneous events SHALL NOT otherwise alter state.
REQ-029 Inputs qualified by a deasserted valid SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately and asynchronously clear busy, busy_count, rd_onehot, rd_valid and err to 0.
REQ-031 An issue or retire coincident with rst_n low SHALL be discarded; operation SHALL resume on the first edge after deassertion.

Verification
REQ-032 NUM_REGS=8, MSB_FIRST=1: issue rd=3 -> next cycle rd_onehot=8'b00010000, rd_valid=1, busy=8'b00010000, busy_count=1.
REQ-033 With busy r3 set: issue rs1=3 -> stall=1 and no state change; retire 3 in the same cycle -> stall still 1, busy=0 next cycle; re-issue accepted the following cycle.
REQ-034 With busy r5 set: same-cycle accept rd=5 from a non-busy state after retire, and accept rd=2 with retire 5 -> busy=8'b00100000, busy_count=1.
REQ-035 Retire rd=6 while idle -> err=1 next cycle and err stays 1; busy unchanged.
REQ-036 NUM_REGS=6, MSB_FIRST=0, ZERO_REG=1: issue rd=0 -> no busy bit set; issue rd=7 -> rd_onehot=0, err=1; set all regs 1..5 busy -> busy_count=5.
REQ-037 Assert rst_n low mid-operation with busy nonzero -> all outputs 0 without a clock edge; a fresh issue after release behaves as REQ-032.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/retire bus and status outputs of the register scoreboard.
// The master drives issue and retire requests. The slave reports the stall and the pending-write state.
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
);
    logic                issue_valid;
    logic [IDX_W-1:0]    issue_rd;
    logic [IDX_W-1:0]    issue_rs1;
    logic [IDX_W-1:0]    issue_rs2;
    logic                retire_valid;
    logic [IDX_W-1:0]    retire_rd;
    logic                stall;
    logic [NUM_REGS-1:0] rd_onehot;
    logic                rd_valid;
    logic [NUM_REGS-1:0] busy;
    logic [IDX_W:0]      busy_count;
    logic                err;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2, retire_valid, retire_rd,
        input  stall, rd_onehot, rd_valid, busy, busy_count, err
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2, retire_valid, retire_rd,
        output stall, rd_onehot, rd_valid, busy, busy_count, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard that tracks pending writes per architectural register.
// It stalls dependent issues and flags protocol errors with a sticky err bit.
module reg_scoreboard #(
    parameter int NUM_REGS  = 8,
    parameter int IDX_W     = 3,
    parameter int MSB_FIRST = 1,
    parameter int ZERO_REG  = 0
) (
    input logic             clk,
    input logic             rst_n,
    reg_scoreboard_if.slave sb
);

    localparam int R0_BIT = (MSB_FIRST != 0) ? NUM_REGS - 1 : 0;
    localparam logic [NUM_REGS-1:0] R0_ONEHOT = NUM_REGS'(1) << R0_BIT;
    // Bits that take part in hazard tracking; reg 0 drops out when hardwired.
    localparam logic [NUM_REGS-1:0] TRACK_MASK = (ZERO_REG != 0) ? ~R0_ONEHOT : '1;

    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) v[(MSB_FIRST != 0) ? NUM_REGS - 1 - i : i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) c = c + (IDX_W+1)'(v[i]);
        return c;
    endfunction

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [IDX_W:0]      busy_count_q, busy_count_d;
    logic [NUM_REGS-1:0] rd_onehot_q, rd_onehot_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic [NUM_REGS-1:0] rd_dec;
    logic [NUM_REGS-1:0] rd_trk, rs1_trk, rs2_trk, ret_trk;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    logic                hazard, accept;
    logic                range_err, retire_err;

    always_comb begin
        rd_dec  = decode(sb.issue_rd);
        rd_trk  = rd_dec & TRACK_MASK;
        rs1_trk = decode(sb.issue_rs1) & TRACK_MASK;
        rs2_trk = decode(sb.issue_rs2) & TRACK_MASK;
        ret_trk = decode(sb.retire_rd) & TRACK_MASK;

        // The hazard uses only the registered busy, so a same-cycle retire does not unblock the issue.
        hazard = |((rd_trk | rs1_trk | rs2_trk) & busy_q);
        accept = sb.issue_valid & ~hazard;

        set_vec = accept          ? rd_trk  : '0;
        clr_vec = sb.retire_valid ? ret_trk : '0;
        // The set is applied after the clear, so it wins when both hit the same register.
        busy_d       = (busy_q & ~clr_vec) | set_vec;
        busy_count_d = popcount(busy_d);

        rd_onehot_d = accept ? rd_dec : rd_onehot_q;
        rd_valid_d  = accept;

        range_err = (sb.issue_valid &
                     (~in_range(sb.issue_rd) | ~in_range(sb.issue_rs1) | ~in_range(sb.issue_rs2))) |
                    (sb.retire_valid & ~in_range(sb.retire_rd));
        // ret_trk is empty for the hardwired reg 0 and for out-of-range indices.
        // Those cases are excluded here. An out-of-range index is still caught by range_err.
        retire_err = sb.retire_valid & (|ret_trk) & ~(|(ret_trk & busy_q));

        err_d = err_q | range_err | retire_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            rd_onehot_q  <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            rd_onehot_q  <= rd_onehot_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
        end
    end

    assign sb.stall      = sb.issue_valid & hazard;
    assign sb.busy       = busy_q;
    assign sb.busy_count = busy_count_q;
    assign sb.rd_onehot  = rd_onehot_q;
    assign sb.rd_valid   = rd_valid_q;
    assign sb.err        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. It covers an 8-register MSB-first instance and a 6-register LSB-first instance with reg 0 hardwired.
module tb_reg_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(8), .IDX_W(3)) ia ();
    reg_scoreboard_if #(.NUM_REGS(6), .IDX_W(3)) ib ();

    reg_scoreboard #(.NUM_REGS(8), .IDX_W(3), .MSB_FIRST(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .sb(ia)
    );
    reg_scoreboard #(.NUM_REGS(6), .IDX_W(3), .MSB_FIRST(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .sb(ib)
    );

    task automatic drive_a(input logic iv, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic rv, input logic [2:0] rr);
        ia.issue_valid = iv; ia.issue_rd = rd; ia.issue_rs1 = rs1; ia.issue_rs2 = rs2;
        ia.retire_valid = rv; ia.retire_rd = rr;
    endtask

    task automatic drive_b(input logic iv, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic rv, input logic [2:0] rr);
        ib.issue_valid = iv; ib.issue_rd = rd; ib.issue_rs1 = rs1; ib.issue_rs2 = rs2;
        ib.retire_valid = rv; ib.retire_rd = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        #2;
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL rst_busy got=%b exp=00000000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd0) begin n_miss++; $display("FAIL rst_count got=%0d exp=0", ia.busy_count); end
        n_vec++; if (ia.rd_onehot !== 8'h00) begin n_miss++; $display("FAIL rst_onehot got=%b exp=00000000", ia.rd_onehot); end
        n_vec++; if (ia.rd_valid !== 1'b0) begin n_miss++; $display("FAIL rst_rdvalid got=%b exp=0", ia.rd_valid); end
        n_vec++; if (ia.err !== 1'b0) begin n_miss++; $display("FAIL rst_err got=%b exp=0", ia.err); end
        n_vec++; if (ib.busy !== 6'b0) begin n_miss++; $display("FAIL rst_b_busy got=%b exp=000000", ib.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_issue_decode();
        drive_a(1, 3, 0, 1, 0, 0);
        #1;
        n_vec++; if (ia.stall !== 1'b0) begin n_miss++; $display("FAIL dec_stall got=%b exp=0", ia.stall); end
        step();
        n_vec++; if (ia.rd_onehot !== 8'b00010000) begin n_miss++; $display("FAIL dec_onehot got=%b exp=00010000", ia.rd_onehot); end
        n_vec++; if (ia.rd_valid !== 1'b1) begin n_miss++; $display("FAIL dec_rdvalid got=%b exp=1", ia.rd_valid); end
        n_vec++; if (ia.busy !== 8'b00010000) begin n_miss++; $display("FAIL dec_busy got=%b exp=00010000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd1) begin n_miss++; $display("FAIL dec_count got=%0d exp=1", ia.busy_count); end
        step();
        n_vec++; if (ia.rd_valid !== 1'b0) begin n_miss++; $display("FAIL dec_pulse got=%b exp=0", ia.rd_valid); end
        n_vec++; if (ia.rd_onehot !== 8'b00010000) begin n_miss++; $display("FAIL dec_hold got=%b exp=00010000", ia.rd_onehot); end
    endtask

    task automatic test_stall_retire();
        drive_a(1, 4, 3, 0, 0, 0);
        #1;
        n_vec++; if (ia.stall !== 1'b1) begin n_miss++; $display("FAIL st_rs1 got=%b exp=1", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'b00010000) begin n_miss++; $display("FAIL st_busy_hold got=%b exp=00010000", ia.busy); end
        n_vec++; if (ia.rd_valid !== 1'b0) begin n_miss++; $display("FAIL st_rdvalid got=%b exp=0", ia.rd_valid); end
        drive_a(1, 4, 3, 0, 1, 3);
        #1;
        n_vec++; if (ia.stall !== 1'b1) begin n_miss++; $display("FAIL st_nobypass got=%b exp=1", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL st_retired got=%b exp=00000000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd0) begin n_miss++; $display("FAIL st_count got=%0d exp=0", ia.busy_count); end
        drive_a(1, 4, 3, 0, 0, 0);
        #1;
        n_vec++; if (ia.stall !== 1'b0) begin n_miss++; $display("FAIL st_reissue got=%b exp=0", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'b00001000) begin n_miss++; $display("FAIL st_re_busy got=%b exp=00001000", ia.busy); end
        n_vec++; if (ia.rd_onehot !== 8'b00001000) begin n_miss++; $display("FAIL st_re_onehot got=%b exp=00001000", ia.rd_onehot); end
        n_vec++; if (ia.rd_valid !== 1'b1) begin n_miss++; $display("FAIL st_re_rdvalid got=%b exp=1", ia.rd_valid); end
        drive_a(0, 0, 0, 0, 1, 4);
        step();
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL st_clear got=%b exp=00000000", ia.busy); end
    endtask

    task automatic test_issue_with_retire();
        drive_a(1, 5, 0, 1, 0, 0);
        step();
        n_vec++; if (ia.busy !== 8'b00000100) begin n_miss++; $display("FAIL iwr_r5 got=%b exp=00000100", ia.busy); end
        drive_a(1, 6, 0, 5, 0, 0);
        #1;
        n_vec++; if (ia.stall !== 1'b1) begin n_miss++; $display("FAIL iwr_rs2 got=%b exp=1", ia.stall); end
        step();
        drive_a(1, 2, 0, 1, 1, 5);
        #1;
        n_vec++; if (ia.stall !== 1'b0) begin n_miss++; $display("FAIL iwr_stall got=%b exp=0", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'b00100000) begin n_miss++; $display("FAIL iwr_busy got=%b exp=00100000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd1) begin n_miss++; $display("FAIL iwr_count got=%0d exp=1", ia.busy_count); end
        n_vec++; if (ia.err !== 1'b0) begin n_miss++; $display("FAIL iwr_err got=%b exp=0", ia.err); end
        drive_a(1, 2, 0, 0, 0, 0);
        #1;
        n_vec++; if (ia.stall !== 1'b1) begin n_miss++; $display("FAIL iwr_rd_hazard got=%b exp=1", ia.stall); end
        drive_a(0, 0, 0, 0, 1, 2);
        step();
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL iwr_clear got=%b exp=00000000", ia.busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] rds [4];
        logic [7:0] exp_oh [4];
        logic [7:0] exp_busy [4];
        rds      = '{3'd0, 3'd1, 3'd2, 3'd7};
        exp_oh   = '{8'b10000000, 8'b01000000, 8'b00100000, 8'b00000001};
        exp_busy = '{8'b10000000, 8'b11000000, 8'b11100000, 8'b11100001};
        for (int k = 0; k < 4; k++) begin
            drive_a(1, rds[k], 3, 3, 0, 0);
            step();
            n_vec++; if (ia.rd_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_rdvalid[%0d] got=%b exp=1", k, ia.rd_valid); end
            n_vec++; if (ia.rd_onehot !== exp_oh[k]) begin n_miss++; $display("FAIL b2b_onehot[%0d] got=%b exp=%b", k, ia.rd_onehot, exp_oh[k]); end
            n_vec++; if (ia.busy !== exp_busy[k]) begin n_miss++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", k, ia.busy, exp_busy[k]); end
        end
        n_vec++; if (ia.busy_count !== 4'd4) begin n_miss++; $display("FAIL b2b_count got=%0d exp=4", ia.busy_count); end
        for (int k = 0; k < 4; k++) begin
            drive_a(0, 0, 0, 0, 1, rds[k]);
            step();
        end
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL b2b_drain got=%b exp=00000000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd0) begin n_miss++; $display("FAIL b2b_drain_count got=%0d exp=0", ia.busy_count); end
        n_vec++; if (ia.err !== 1'b0) begin n_miss++; $display("FAIL b2b_err got=%b exp=0", ia.err); end
    endtask

    task automatic test_ignored_valid();
        drive_a(1, 1, 3, 3, 0, 0);
        step();
        drive_a(0, 1, 1, 1, 0, 6);
        #1;
        n_vec++; if (ia.stall !== 1'b0) begin n_miss++; $display("FAIL ign_stall got=%b exp=0", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'b01000000) begin n_miss++; $display("FAIL ign_busy got=%b exp=01000000", ia.busy); end
        n_vec++; if (ia.rd_valid !== 1'b0) begin n_miss++; $display("FAIL ign_rdvalid got=%b exp=0", ia.rd_valid); end
        n_vec++; if (ia.err !== 1'b0) begin n_miss++; $display("FAIL ign_err got=%b exp=0", ia.err); end
        drive_a(0, 0, 0, 0, 1, 1);
        step();
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL ign_clear got=%b exp=00000000", ia.busy); end
    endtask

    task automatic test_zero_reg();
        drive_b(1, 0, 0, 0, 0, 0);
        step();
        n_vec++; if (ib.busy !== 6'b000000) begin n_miss++; $display("FAIL zr_rd0_busy got=%b exp=000000", ib.busy); end
        n_vec++; if (ib.busy_count !== 4'd0) begin n_miss++; $display("FAIL zr_rd0_count got=%0d exp=0", ib.busy_count); end
        drive_b(0, 0, 0, 0, 1, 0);
        step();
        n_vec++; if (ib.err !== 1'b0) begin n_miss++; $display("FAIL zr_ret0_err got=%b exp=0", ib.err); end
        for (int k = 1; k <= 5; k++) begin
            drive_b(1, 3'(k), 0, 0, 0, 0);
            step();
            n_vec++; if (ib.busy_count !== 4'(k)) begin n_miss++; $display("FAIL zr_count[%0d] got=%0d exp=%0d", k, ib.busy_count, k); end
        end
        n_vec++; if (ib.busy !== 6'b111110) begin n_miss++; $display("FAIL zr_all_busy got=%b exp=111110", ib.busy); end
        n_vec++; if (ib.rd_onehot !== 6'b100000) begin n_miss++; $display("FAIL zr_onehot5 got=%b exp=100000", ib.rd_onehot); end
        drive_b(1, 0, 3, 0, 0, 0);
        #1;
        n_vec++; if (ib.stall !== 1'b1) begin n_miss++; $display("FAIL zr_rs1_stall got=%b exp=1", ib.stall); end
        drive_b(1, 7, 0, 0, 0, 0);
        #1;
        n_vec++; if (ib.stall !== 1'b0) begin n_miss++; $display("FAIL zr_rd7_stall got=%b exp=0", ib.stall); end
        step();
        n_vec++; if (ib.rd_onehot !== 6'b000000) begin n_miss++; $display("FAIL zr_rd7_onehot got=%b exp=000000", ib.rd_onehot); end
        n_vec++; if (ib.err !== 1'b1) begin n_miss++; $display("FAIL zr_rd7_err got=%b exp=1", ib.err); end
        n_vec++; if (ib.busy !== 6'b111110) begin n_miss++; $display("FAIL zr_rd7_busy got=%b exp=111110", ib.busy); end
    endtask

    task automatic test_err_sticky();
        drive_a(0, 0, 0, 0, 1, 6);
        step();
        n_vec++; if (ia.err !== 1'b1) begin n_miss++; $display("FAIL err_set got=%b exp=1", ia.err); end
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL err_busy got=%b exp=00000000", ia.busy); end
        step(); step(); step();
        n_vec++; if (ia.err !== 1'b1) begin n_miss++; $display("FAIL err_sticky got=%b exp=1", ia.err); end
    endtask

    task automatic test_set_wins();
        drive_a(1, 4, 3, 3, 1, 4);
        #1;
        n_vec++; if (ia.stall !== 1'b0) begin n_miss++; $display("FAIL sw_stall got=%b exp=0", ia.stall); end
        step();
        n_vec++; if (ia.busy !== 8'b00001000) begin n_miss++; $display("FAIL sw_busy got=%b exp=00001000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd1) begin n_miss++; $display("FAIL sw_count got=%0d exp=1", ia.busy_count); end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0;
        #1;
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL mr_busy got=%b exp=00000000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd0) begin n_miss++; $display("FAIL mr_count got=%0d exp=0", ia.busy_count); end
        n_vec++; if (ia.rd_onehot !== 8'h00) begin n_miss++; $display("FAIL mr_onehot got=%b exp=00000000", ia.rd_onehot); end
        n_vec++; if (ia.rd_valid !== 1'b0) begin n_miss++; $display("FAIL mr_rdvalid got=%b exp=0", ia.rd_valid); end
        n_vec++; if (ia.err !== 1'b0) begin n_miss++; $display("FAIL mr_err got=%b exp=0", ia.err); end
        n_vec++; if (ib.busy !== 6'b0) begin n_miss++; $display("FAIL mr_b_busy got=%b exp=000000", ib.busy); end
        n_vec++; if (ib.err !== 1'b0) begin n_miss++; $display("FAIL mr_b_err got=%b exp=0", ib.err); end
        drive_a(1, 2, 0, 0, 0, 0);
        step();
        n_vec++; if (ia.busy !== 8'h00) begin n_miss++; $display("FAIL mr_discard got=%b exp=00000000", ia.busy); end
        rst_n = 1'b1;
        drive_a(1, 3, 0, 1, 0, 0);
        step();
        n_vec++; if (ia.rd_onehot !== 8'b00010000) begin n_miss++; $display("FAIL mr_onehot2 got=%b exp=00010000", ia.rd_onehot); end
        n_vec++; if (ia.rd_valid !== 1'b1) begin n_miss++; $display("FAIL mr_rdvalid2 got=%b exp=1", ia.rd_valid); end
        n_vec++; if (ia.busy !== 8'b00010000) begin n_miss++; $display("FAIL mr_busy2 got=%b exp=00010000", ia.busy); end
        n_vec++; if (ia.busy_count !== 4'd1) begin n_miss++; $display("FAIL mr_count2 got=%0d exp=1", ia.busy_count); end
    endtask

    initial begin
        test_reset();
        test_issue_decode();
        test_stall_retire();
        test_issue_with_retire();
        test_back_to_back();
        test_ignored_valid();
        test_zero_reg();
        test_err_sticky();
        test_set_wins();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
